seg7_scan_capture: RTL and testbench

- Monitors a multiplexed common-anode 7-segment display bus: active-low segments plus active-low per-digit anode strobes.
- Reconstructs the BCD value of every digit, which is the inverse of the BCD-to-7-segment common-anode encoder.
- Publishes one complete frame of digits through a valid/ready handshake.
- Used for display loop-back self-test and for on-chip capture of externally driven displays.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_bcd.sv | 35 +++
 rtl/seg7_scan_capture.sv | 197 +++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern table, BCD codes and
// capture FSM states for the scan capture block.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the common-anode BCD encoder:
// segment pattern to {bcd, blank, err}.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);

  always_comb begin
    bcd   = BCD_ERR;
    blank = 1'b0;
    err   = 1'b0;
    unique case (seg)
      SEG_0: bcd = 4'd0;
      SEG_1: bcd = 4'd1;
      SEG_2: bcd = 4'd2;
      SEG_3: bcd = 4'd3;
      SEG_4: bcd = 4'd4;
      SEG_5: bcd = 4'd5;
      SEG_6: bcd = 4'd6;
      SEG_7: bcd = 4'd7;
      SEG_8: bcd = 4'd8;
      SEG_9: bcd = 4'd9;
      SEG_BLANK: begin
        bcd   = BCD_BLANK;
        blank = 1'b1;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed common-anode 7-segment bus into
// complete BCD frames published via valid/ready.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [4*DIGITS-1:0]   frame_bcd,
  output logic [DIGITS-1:0]     frame_blank,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  conflict,
  output logic                  overrun
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][6:0]        seg_sync_q, seg_sync_d;
  logic [SYNC_STAGES-1:0][DIGITS-1:0] an_sync_q, an_sync_d;
  logic [6:0]        s_seg;
  logic [DIGITS-1:0] s_an;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_lat_q, seg_lat_d;
  logic [DIGITS-1:0] an_lat_q, an_lat_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DIGITS-1:0] mask_q, mask_d;

  logic [DIGITS-1:0][3:0] scr_bcd_q, scr_bcd_d;
  logic [DIGITS-1:0]      scr_blank_q, scr_blank_d;
  logic [DIGITS-1:0]      scr_err_q, scr_err_d;
  logic [DIGITS-1:0][3:0] frm_bcd_q, frm_bcd_d;
  logic [DIGITS-1:0]      frm_blank_q, frm_blank_d;
  logic [DIGITS-1:0]      frm_err_q, frm_err_d;
  logic valid_q, valid_d;
  logic conflict_q, conflict_d;
  logic overrun_q, overrun_d;

  logic [3:0]        dec_bcd;
  logic              dec_blank;
  logic              dec_err;
  logic [DIGITS-1:0] an_act;
  logic              multi;
  logic              one_hot;
  logic [IW-1:0]     idx_new;
  logic              eval;

  assign s_seg   = seg_sync_q[SYNC_STAGES-1];
  assign s_an    = an_sync_q[SYNC_STAGES-1];
  assign an_act  = ~s_an;
  assign multi   = |(an_act & (an_act - DIGITS'(1)));
  assign one_hot = (|an_act) && !multi;

  seg7_to_bcd u_dec (
    .seg   (s_seg),
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .err   (dec_err)
  );

  always_comb begin
    idx_new = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_act[i]) idx_new = IW'(i);
    end
  end

  always_comb begin
    seg_sync_d = {seg_sync_q[SYNC_STAGES-2:0], seg_n};
    an_sync_d  = {an_sync_q[SYNC_STAGES-2:0], an_n};
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seg_lat_d   = seg_lat_q;
    an_lat_d    = an_lat_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    scr_bcd_d   = scr_bcd_q;
    scr_blank_d = scr_blank_q;
    scr_err_d   = scr_err_q;
    frm_bcd_d   = frm_bcd_q;
    frm_blank_d = frm_blank_q;
    frm_err_d   = frm_err_q;
    valid_d     = valid_q;
    conflict_d  = 1'b0;
    overrun_d   = 1'b0;
    eval        = 1'b0;

    // Frame hand-off; a capture below may still set a mask bit.
    if (&mask_q) begin
      mask_d = '0;
      if (!valid_q || frame_ready) begin
        frm_bcd_d   = scr_bcd_q;
        frm_blank_d = scr_blank_q;
        frm_err_d   = scr_err_q;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: eval = 1'b1;
      SETTLE: begin
        if (s_an != an_lat_q || s_seg != seg_lat_q) begin
          eval = 1'b1;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          if (cnt_q >= CNT_MAX - CW'(1)) begin
            scr_bcd_d[idx_q]   = dec_bcd;
            scr_blank_d[idx_q] = dec_blank;
            scr_err_d[idx_q]   = dec_err;
            mask_d[idx_q]      = 1'b1;
            state_d            = HOLD;
          end
        end
      end
      HOLD: if (s_an != an_lat_q) eval = 1'b1;
      default: state_d = IDLE;
    endcase

    if (eval) begin
      state_d  = IDLE;
      an_lat_d = s_an;
      if (multi) begin
        conflict_d = 1'b1;
      end else if (one_hot) begin
        state_d   = SETTLE;
        idx_d     = idx_new;
        seg_lat_d = s_seg;
        cnt_d     = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sync_q  <= '1;
      an_sync_q   <= '1;
      state_q     <= IDLE;
      idx_q       <= '0;
      seg_lat_q   <= '1;
      an_lat_q    <= '1;
      cnt_q       <= '0;
      mask_q      <= '0;
      scr_bcd_q   <= '0;
      scr_blank_q <= '0;
      scr_err_q   <= '0;
      frm_bcd_q   <= '0;
      frm_blank_q <= '0;
      frm_err_q   <= '0;
      valid_q     <= 1'b0;
      conflict_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      seg_sync_q  <= seg_sync_d;
      an_sync_q   <= an_sync_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      seg_lat_q   <= seg_lat_d;
      an_lat_q    <= an_lat_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      scr_bcd_q   <= scr_bcd_d;
      scr_blank_q <= scr_blank_d;
      scr_err_q   <= scr_err_d;
      frm_bcd_q   <= frm_bcd_d;
      frm_blank_q <= frm_blank_d;
      frm_err_q   <= frm_err_d;
      valid_q     <= valid_d;
      conflict_q  <= conflict_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_bcd   = frm_bcd_q;
  assign frame_blank = frm_blank_q;
  assign frame_err   = frm_err_q;
  assign conflict    = conflict_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (DIGITS=4,
// STABLE_CYCLES=8, SYNC_STAGES=2).
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;
  logic        conflict;
  logic        overrun;

  localparam logic [6:0] PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100
  };
  localparam logic [6:0] PBLANK = 7'b1111111;
  localparam logic [6:0] PBAD   = 7'b1110000;

  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int conf_cnt = 0;
  int ovr_cnt = 0;

  seg7_scan_capture #(
    .DIGITS        (4),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_bcd   (frame_bcd),
    .frame_blank (frame_blank),
    .frame_err   (frame_err),
    .conflict    (conflict),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid && frame_ready) acc_cnt++;
    if (conflict) conf_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic show(input int d, input logic [6:0] p, input int cyc);
    an_n  = ~(4'b0001 << d);
    seg_n = p;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic idle(input int cyc);
    an_n  = '1;
    seg_n = '1;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    frame_ready = 1'b0;
    idle(3);
    n_chk++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", frame_valid);
    end
    n_chk++;
    if (frame_bcd !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_bcd: got %h want 0000", frame_bcd);
    end
    n_chk++;
    if ({frame_blank, frame_err} !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_flags: got %b/%b want 0/0", frame_blank, frame_err);
    end
    n_chk++;
    if ({conflict, overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_pulses: got %b%b want 00", conflict, overrun);
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_loopback;
    int a0;
    a0 = acc_cnt;
    frame_ready = 1'b1;
    show(0, PAT[1], 20);
    show(1, PAT[2], 20);
    show(2, PAT[3], 20);
    show(3, PAT[4], 20);
    idle(4);
    n_chk++;
    if (acc_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL lb_frames: got %0d want 1", acc_cnt - a0);
    end
    n_chk++;
    if (frame_bcd !== 16'h4321) begin
      n_fail++;
      $display("FAIL lb_bcd: got %h want 4321", frame_bcd);
    end
    n_chk++;
    if ({frame_blank, frame_err} !== 8'h0) begin
      n_fail++;
      $display("FAIL lb_flags: got %b/%b want 0/0", frame_blank, frame_err);
    end
  endtask

  task automatic test_glitch;
    int a0;
    a0 = acc_cnt;
    show(0, PAT[1], 5);
    show(0, PAT[2], 12);
    show(1, PAT[2], 20);
    show(2, PAT[3], 20);
    show(3, PAT[4], 20);
    idle(4);
    n_chk++;
    if (acc_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL gl_frames: got %0d want 1", acc_cnt - a0);
    end
    n_chk++;
    if (frame_bcd !== 16'h4322) begin
      n_fail++;
      $display("FAIL gl_bcd: got %h want 4322", frame_bcd);
    end
  endtask

  task automatic test_blank_invalid;
    show(0, PAT[0], 20);
    show(1, PAT[9], 20);
    show(2, PBLANK, 20);
    show(3, PBAD, 20);
    idle(4);
    n_chk++;
    if (frame_bcd !== 16'hEF90) begin
      n_fail++;
      $display("FAIL bi_bcd: got %h want ef90", frame_bcd);
    end
    n_chk++;
    if (frame_blank !== 4'b0100) begin
      n_fail++;
      $display("FAIL bi_blank: got %b want 0100", frame_blank);
    end
    n_chk++;
    if (frame_err !== 4'b1000) begin
      n_fail++;
      $display("FAIL bi_err: got %b want 1000", frame_err);
    end
  endtask

  task automatic test_conflict;
    int a0;
    int c0;
    a0 = acc_cnt;
    c0 = conf_cnt;
    show(0, PAT[5], 20);
    show(1, PAT[6], 20);
    an_n  = 4'b1100;
    seg_n = PAT[7];
    repeat (10) @(negedge clk);
    idle(6);
    n_chk++;
    if (conf_cnt - c0 !== 10) begin
      n_fail++;
      $display("FAIL cf_pulses: got %0d want 10", conf_cnt - c0);
    end
    n_chk++;
    if (acc_cnt !== a0) begin
      n_fail++;
      $display("FAIL cf_noframe: got %0d want %0d", acc_cnt, a0);
    end
    show(2, PAT[7], 20);
    show(3, PAT[8], 20);
    idle(4);
    n_chk++;
    if (acc_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL cf_frames: got %0d want 1", acc_cnt - a0);
    end
    n_chk++;
    if (frame_bcd !== 16'h8765) begin
      n_fail++;
      $display("FAIL cf_bcd: got %h want 8765", frame_bcd);
    end
  endtask

  task automatic test_backpressure;
    int a0;
    int o0;
    a0 = acc_cnt;
    o0 = ovr_cnt;
    frame_ready = 1'b0;
    show(0, PAT[1], 20);
    show(1, PAT[2], 20);
    show(2, PAT[3], 20);
    show(3, PAT[4], 20);
    n_chk++;
    if (frame_valid !== 1'b1 || frame_bcd !== 16'h4321) begin
      n_fail++;
      $display("FAIL bp_first: got %b/%h want 1/4321", frame_valid, frame_bcd);
    end
    n_chk++;
    if (ovr_cnt !== o0) begin
      n_fail++;
      $display("FAIL bp_no_ovr: got %0d want %0d", ovr_cnt, o0);
    end
    show(0, PAT[5], 20);
    show(1, PAT[6], 20);
    show(2, PAT[7], 20);
    show(3, PAT[8], 20);
    idle(4);
    n_chk++;
    if (ovr_cnt - o0 !== 1) begin
      n_fail++;
      $display("FAIL bp_overrun: got %0d want 1", ovr_cnt - o0);
    end
    n_chk++;
    if (frame_valid !== 1'b1 || frame_bcd !== 16'h4321) begin
      n_fail++;
      $display("FAIL bp_held: got %b/%h want 1/4321", frame_valid, frame_bcd);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    n_chk++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drop: got %b want 0", frame_valid);
    end
    n_chk++;
    if (acc_cnt - a0 !== 1 || frame_bcd !== 16'h4321) begin
      n_fail++;
      $display("FAIL bp_accept: got %0d/%h want 1/4321", acc_cnt - a0, frame_bcd);
    end
  endtask

  task automatic test_reset_mid;
    int a0;
    frame_ready = 1'b1;
    show(0, PAT[9], 20);
    show(1, PAT[9], 20);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (frame_valid !== 1'b0 || frame_bcd !== 16'h0) begin
      n_fail++;
      $display("FAIL rm_out: got %b/%h want 0/0000", frame_valid, frame_bcd);
    end
    n_chk++;
    if ({frame_blank, frame_err, conflict, overrun} !== 10'h0) begin
      n_fail++;
      $display("FAIL rm_flags: got %b %b %b%b want 0",
               frame_blank, frame_err, conflict, overrun);
    end
    idle(2);
    rst_n = 1'b1;
    idle(3);
    a0 = acc_cnt;
    show(2, PAT[1], 20);
    show(3, PAT[2], 20);
    idle(4);
    n_chk++;
    if (acc_cnt !== a0) begin
      n_fail++;
      $display("FAIL rm_partial: got %0d want %0d", acc_cnt, a0);
    end
    show(0, PAT[3], 20);
    show(1, PAT[4], 20);
    idle(4);
    n_chk++;
    if (acc_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL rm_frames: got %0d want 1", acc_cnt - a0);
    end
    n_chk++;
    if (frame_bcd !== 16'h2143) begin
      n_fail++;
      $display("FAIL rm_bcd: got %h want 2143", frame_bcd);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    an_n        = '1;
    seg_n       = '1;
    frame_ready = 1'b0;
    test_reset();
    test_loopback();
    test_glitch();
    test_blank_invalid();
    test_conflict();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
